// File: rtl/pong_pkg.sv
// Shared Pong definitions: match state encodings, playfield geometry and
// default frame counts for the match sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_REFILL = 3'd3,
        S_OVER   = 3'd4
    } game_state_t;

    localparam int PADDLE_WIDTH  = 10;
    localparam int PADDLE_LENGTH = 60;
    localparam int PADDLE_ONE_X  = 20;
    localparam int PADDLE_TWO_X  = 610;
    localparam int BALL_SIZE     = 8;

    localparam int DEF_BALLS         = 3;
    localparam int DEF_WIN_SCORE     = 9;
    localparam int DEF_SERVE_FRAMES  = 60;
    localparam int DEF_REFILL_FRAMES = 127;
    localparam int DEF_OVER_FRAMES   = 127;
    localparam int DEF_TIMER_W       = 7;

    // Increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Status inputs from the playfield and match outputs toward the ball
// datapath, 7-segment display and sound blocks.
interface game_sequencer_if;
    logic       endofframe;
    logic       isMoving;
    logic [1:0] collided;
    logic [1:0] missed;
    logic       restart;
    logic       score_clr;
    logic [7:0] score_one;
    logic [7:0] score_two;
    logic [2:0] balls_left;
    logic [7:0] rally;
    logic       game_over;
    logic [2:0] state_dbg;

    modport master (
        input  endofframe, isMoving, collided, missed,
        output restart, score_clr, score_one, score_two, balls_left,
               rally, game_over, state_dbg
    );

    modport slave (
        output endofframe, isMoving, collided, missed,
        input  restart, score_clr, score_one, score_two, balls_left,
               rally, game_over, state_dbg
    );
endinterface

// File: rtl/game_sequencer_frame_timer.sv
// Loadable frame down-counter: steps once per frame_tick and parks at zero.
module frame_timer #(
    parameter int TIMER_W = 7
) (
    input  logic               clk50M,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               frame_tick,
    output logic [TIMER_W-1:0] count,
    output logic               done
);

    // Load wins over a coincident tick; no wrap below zero.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (frame_tick && count != '0)
            count <= count - TIMER_W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/game_sequencer.sv
// Pong match controller: serve / play / refill / game-over sequencing,
// scores, remaining balls and rally count.
module game_sequencer
    import pong_pkg::*;
#(
    parameter int BALLS         = DEF_BALLS,
    parameter int WIN_SCORE     = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES  = DEF_SERVE_FRAMES,
    parameter int REFILL_FRAMES = DEF_REFILL_FRAMES,
    parameter int OVER_FRAMES   = DEF_OVER_FRAMES,
    parameter int TIMER_W       = DEF_TIMER_W
) (
    input logic             clk50M,
    input logic             reset,
    game_sequencer_if.master bus
);

    localparam logic [2:0]         BALLS_Q  = 3'(BALLS);
    localparam logic [7:0]         WIN_Q    = 8'(WIN_SCORE);
    localparam logic [TIMER_W-1:0] SERVE_Q  = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] REFILL_Q = TIMER_W'(REFILL_FRAMES);
    localparam logic [TIMER_W-1:0] OVER_Q   = TIMER_W'(OVER_FRAMES);

    game_state_t state, state_next;

    logic       eof_q;
    logic [1:0] col_q, mis_q;
    logic       frame_tick;
    logic [1:0] col_rise, mis_rise;

    logic [7:0] score_one_q, score_two_q, rally_q;
    logic [2:0] balls_q;
    logic       restart_q, game_over_q, score_clr_q;

    logic [7:0] score_one_d, score_two_d, rally_d;
    logic [2:0] balls_d;
    logic       score_clr_d;

    logic [7:0] s1_inc, s2_inc;
    logic [2:0] balls_dec;
    logic       match_end;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic [TIMER_W-1:0] tmr_count;
    logic               tmr_done;

    // Previous-cycle copies of the level inputs for rising-edge detection.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            eof_q <= 1'b0;
            col_q <= '0;
            mis_q <= '0;
        end else begin
            eof_q <= bus.endofframe;
            col_q <= bus.collided;
            mis_q <= bus.missed;
        end
    end

    assign frame_tick = bus.endofframe & ~eof_q;
    assign col_rise   = bus.collided & ~col_q;
    assign mis_rise   = bus.missed & ~mis_q;

    // A left-wall miss scores for the right player and takes precedence.
    assign s1_inc    = sat_inc8(score_one_q);
    assign s2_inc    = sat_inc8(score_two_q);
    assign balls_dec = (balls_q == '0) ? '0 : balls_q - 3'd1;
    assign match_end = (mis_rise[0] ? (s2_inc >= WIN_Q) : (s1_inc >= WIN_Q))
                     || (balls_dec == '0);

    frame_timer #(.TIMER_W(TIMER_W)) u_tmr (
        .clk50M    (clk50M),
        .reset     (reset),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .frame_tick(frame_tick),
        .count     (tmr_count),
        .done      (tmr_done)
    );

    // State register.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decision; undefined encodings fall back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:           if (bus.isMoving) state_next = S_SERVE;
            S_SERVE, S_REFILL: if (tmr_done && bus.isMoving) state_next = S_PLAY;
            S_PLAY:           if (|mis_rise) state_next = match_end ? S_OVER : S_REFILL;
            S_OVER:           if (tmr_done) state_next = S_IDLE;
            default:          state_next = S_IDLE;
        endcase
    end

    // Counter updates and timer loads implied by the current transition.
    always_comb begin
        score_clr_d = 1'b0;
        score_one_d = score_one_q;
        score_two_d = score_two_q;
        balls_d     = balls_q;
        rally_d     = rally_q;
        tmr_load    = (state_next != state) &&
                      (state_next == S_SERVE || state_next == S_REFILL || state_next == S_OVER);
        tmr_val     = (state_next == S_SERVE)  ? SERVE_Q :
                      (state_next == S_REFILL) ? REFILL_Q : OVER_Q;
        case (state)
            S_IDLE: begin
                if (bus.isMoving) begin
                    score_clr_d = 1'b1;
                    score_one_d = '0;
                    score_two_d = '0;
                    rally_d     = '0;
                    balls_d     = BALLS_Q;
                end
            end
            S_SERVE, S_REFILL: begin
                if (state_next == S_PLAY) rally_d = '0;
            end
            S_PLAY: begin
                if (|mis_rise) begin
                    if (mis_rise[0]) score_two_d = s2_inc;
                    else             score_one_d = s1_inc;
                    balls_d = balls_dec;
                end else if (|col_rise) begin
                    rally_d = sat_inc8(rally_q);
                end
            end
            default: ;
        endcase
    end

    // Registered outputs; restart and game_over follow the next state.
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            restart_q   <= 1'b1;
            game_over_q <= 1'b0;
            score_clr_q <= 1'b0;
            score_one_q <= '0;
            score_two_q <= '0;
            balls_q     <= BALLS_Q;
            rally_q     <= '0;
        end else begin
            restart_q   <= (state_next != S_PLAY);
            game_over_q <= (state_next == S_OVER);
            score_clr_q <= score_clr_d;
            score_one_q <= score_one_d;
            score_two_q <= score_two_d;
            balls_q     <= balls_d;
            rally_q     <= rally_d;
        end
    end

    assign bus.restart    = restart_q;
    assign bus.game_over  = game_over_q;
    assign bus.score_clr  = score_clr_q;
    assign bus.score_one  = score_one_q;
    assign bus.score_two  = score_two_q;
    assign bus.balls_left = balls_q;
    assign bus.rally      = rally_q;
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed match on default parameters, a vector
// table on a short-match instance, and random play against a rules model.
module tb_game_sequencer;

    logic clk50M = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;

    always #5 clk50M = ~clk50M;

    game_sequencer_if bus1();
    game_sequencer_if bus2();

    game_sequencer dut (.clk50M(clk50M), .reset(reset), .bus(bus1));

    localparam int B2 = 7, W2 = 2, SF2 = 1, RF2 = 1, OF2 = 2;
    game_sequencer #(.BALLS(B2), .WIN_SCORE(W2), .SERVE_FRAMES(SF2),
                     .REFILL_FRAMES(RF2), .OVER_FRAMES(OF2), .TIMER_W(7))
        dut2 (.clk50M(clk50M), .reset(reset2), .bus(bus2));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       mv;
        logic       eof;
        logic [1:0] col;
        logic [1:0] mis;
        logic [2:0] st;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [2:0] b;
        logic [7:0] r;
        logic       clr;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic mv, logic eof, logic [1:0] col, logic [1:0] mis,
                                logic [2:0] st, logic [7:0] s1, logic [7:0] s2,
                                logic [2:0] b, logic [7:0] r, logic clr);
        vec_t v;
        v.mv = mv; v.eof = eof; v.col = col; v.mis = mis; v.st = st;
        v.s1 = s1; v.s2 = s2; v.b = b; v.r = r; v.clr = clr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50M);
        #1;
    endtask

    task automatic ticks1(input int n);
        repeat (n) begin
            bus1.endofframe = 1'b1; step();
            bus1.endofframe = 1'b0; step();
        end
    endtask

    initial begin
        bus1.endofframe = 0; bus1.isMoving = 0; bus1.collided = 0; bus1.missed = 0;
        bus2.endofframe = 0; bus2.isMoving = 0; bus2.collided = 0; bus2.missed = 0;

        // Table for the short-match instance (BALLS=7, WIN_SCORE=2).
        tbl[0]  = mk(1, 0, 2'b00, 2'b00, 3'd1, 0, 0, 7, 0, 1);
        tbl[1]  = mk(0, 1, 2'b00, 2'b00, 3'd1, 0, 0, 7, 0, 0);
        tbl[2]  = mk(1, 0, 2'b00, 2'b00, 3'd2, 0, 0, 7, 0, 0);
        tbl[3]  = mk(0, 0, 2'b01, 2'b00, 3'd2, 0, 0, 7, 1, 0);
        tbl[4]  = mk(0, 0, 2'b00, 2'b10, 3'd3, 1, 0, 6, 1, 0);
        tbl[5]  = mk(0, 1, 2'b00, 2'b00, 3'd3, 1, 0, 6, 1, 0);
        tbl[6]  = mk(1, 0, 2'b00, 2'b00, 3'd2, 1, 0, 6, 0, 0);
        tbl[7]  = mk(0, 0, 2'b00, 2'b11, 3'd3, 1, 1, 5, 0, 0);
        tbl[8]  = mk(0, 1, 2'b00, 2'b00, 3'd3, 1, 1, 5, 0, 0);
        tbl[9]  = mk(1, 0, 2'b00, 2'b00, 3'd2, 1, 1, 5, 0, 0);
        tbl[10] = mk(0, 0, 2'b01, 2'b10, 3'd4, 2, 1, 4, 0, 0);
        tbl[11] = mk(1, 1, 2'b00, 2'b00, 3'd4, 2, 1, 4, 0, 0);
        tbl[12] = mk(1, 0, 2'b00, 2'b00, 3'd4, 2, 1, 4, 0, 0);
        tbl[13] = mk(1, 1, 2'b00, 2'b00, 3'd4, 2, 1, 4, 0, 0);
        tbl[14] = mk(1, 0, 2'b00, 2'b00, 3'd0, 2, 1, 4, 0, 0);
        tbl[15] = mk(1, 0, 2'b00, 2'b00, 3'd1, 0, 0, 7, 0, 1);

        // ---- reset values
        step(); step();
        chk("rst_state",   bus1.state_dbg, 0);
        chk("rst_restart", bus1.restart, 1);
        chk("rst_clr",     bus1.score_clr, 0);
        chk("rst_scores",  {bus1.score_one, bus1.score_two}, 0);
        chk("rst_balls",   bus1.balls_left, 3);
        chk("rst_rally",   bus1.rally, 0);
        chk("rst_over",    bus1.game_over, 0);
        #2; reset = 1'b0; reset2 = 1'b0;
        step();

        // ---- start a match, serve after exactly 60 frames
        bus1.isMoving = 1; step();
        chk("start_state", bus1.state_dbg, 1);
        chk("start_clr",   bus1.score_clr, 1);
        bus1.isMoving = 0; step();
        chk("clr_pulse_once", bus1.score_clr, 0);
        ticks1(59);
        bus1.isMoving = 1; step();
        chk("serve_early", bus1.state_dbg, 1);
        bus1.isMoving = 0;
        ticks1(1);
        bus1.isMoving = 1; step();
        chk("serve_state",   bus1.state_dbg, 2);
        chk("serve_restart", bus1.restart, 0);
        bus1.isMoving = 0;

        // ---- rally counting with held levels
        bus1.collided = 2'b01; step();
        chk("rally_first", bus1.rally, 1);
        repeat (4) step();
        chk("rally_held", bus1.rally, 1);
        bus1.collided = 2'b00; step();
        bus1.collided = 2'b10; step();
        bus1.collided = 2'b00; step();
        bus1.collided = 2'b11; step();
        chk("rally_three", bus1.rally, 3);
        bus1.collided = 2'b00; step();

        // ---- held miss counts once
        bus1.missed = 2'b01; step();
        chk("miss1_state", bus1.state_dbg, 3);
        chk("miss1_s2",    bus1.score_two, 1);
        chk("miss1_balls", bus1.balls_left, 2);
        repeat (19) step();
        chk("miss_held", {bus1.score_two, 5'b0, bus1.balls_left}, {8'd1, 8'd2});
        bus1.missed = 2'b00; step();
        bus1.collided = 2'b01; bus1.missed = 2'b10; step();
        bus1.collided = 2'b00; bus1.missed = 2'b00; step();
        chk("refill_ignores", {bus1.rally, bus1.score_one}, {8'd3, 8'd0});

        // ---- refill waits 127 frames
        ticks1(126);
        bus1.isMoving = 1; step();
        chk("refill_early", bus1.state_dbg, 3);
        bus1.isMoving = 0;
        ticks1(1);
        bus1.isMoving = 1; step();
        chk("refill_play",  bus1.state_dbg, 2);
        chk("refill_rally", bus1.rally, 0);
        bus1.isMoving = 0;

        // ---- run out of balls
        bus1.missed = 2'b01; step(); bus1.missed = 2'b00; step();
        chk("miss2", {bus1.state_dbg, bus1.score_two, bus1.balls_left}, {3'd3, 8'd2, 3'd1});
        ticks1(127);
        bus1.isMoving = 1; step(); bus1.isMoving = 0;
        chk("play3", bus1.state_dbg, 2);
        bus1.missed = 2'b01; step(); bus1.missed = 2'b00;
        chk("over_state", bus1.state_dbg, 4);
        chk("over_flag",  bus1.game_over, 1);
        chk("over_s2",    bus1.score_two, 3);
        chk("over_balls", bus1.balls_left, 0);
        bus1.isMoving = 1;
        ticks1(126);
        chk("over_hold", {bus1.state_dbg, bus1.score_two}, {3'd4, 8'd3});
        ticks1(1);
        bus1.isMoving = 0;
        chk("over_idle",   bus1.state_dbg, 0);
        chk("over_clear",  bus1.game_over, 0);
        chk("idle_frozen", bus1.score_two, 3);

        // ---- asynchronous reset in the middle of REFILL
        bus1.isMoving = 1; step(); bus1.isMoving = 0;
        ticks1(60);
        bus1.isMoving = 1; step(); bus1.isMoving = 0;
        bus1.missed = 2'b10; step(); bus1.missed = 2'b00;
        chk("pre_rst", {bus1.state_dbg, bus1.score_one}, {3'd3, 8'd1});
        ticks1(77);
        chk("refill_timer", dut.u_tmr.count, 50);
        #2; reset = 1'b1; #1;
        chk("arst_state",   bus1.state_dbg, 0);
        chk("arst_scores",  {bus1.score_one, bus1.score_two}, 0);
        chk("arst_balls",   bus1.balls_left, 3);
        chk("arst_restart", bus1.restart, 1);
        step(); reset = 1'b0; step();

        // ---- table-driven vectors on the short-match instance
        for (int i = 0; i < 16; i++) begin
            bus2.isMoving = tbl[i].mv; bus2.endofframe = tbl[i].eof;
            bus2.collided = tbl[i].col; bus2.missed = tbl[i].mis;
            step();
            chk($sformatf("tbl%0d_state", i), bus2.state_dbg, tbl[i].st);
            chk($sformatf("tbl%0d_scores", i), {bus2.score_one, bus2.score_two}, {tbl[i].s1, tbl[i].s2});
            chk($sformatf("tbl%0d_balls", i), bus2.balls_left, tbl[i].b);
            chk($sformatf("tbl%0d_rally", i), bus2.rally, tbl[i].r);
            chk($sformatf("tbl%0d_clr", i), bus2.score_clr, tbl[i].clr);
            chk($sformatf("tbl%0d_flags", i), {bus2.restart, bus2.game_over},
                {tbl[i].st != 3'd2, tbl[i].st == 3'd4});
        end

        // ---- random play against a rules model
        bus2.isMoving = 0; bus2.endofframe = 0; bus2.collided = 0; bus2.missed = 0;
        reset2 = 1'b1; step(); reset2 = 1'b0;
        begin
            int m_st, m_t, m_s1, m_s2, m_b, m_r, m_clr;
            logic       p_eof;
            logic [1:0] p_col, p_mis;
            logic       ft, hit;
            logic [1:0] mr;
            logic [63:0] exp_v, act_v;
            m_st = 0; m_t = 0; m_s1 = 0; m_s2 = 0; m_b = B2; m_r = 0;
            p_eof = 0; p_col = 0; p_mis = 0;
            for (int c = 0; c < 3000; c++) begin
                if (c == 1500) begin
                    #2; reset2 = 1'b1; #1;
                    chk("rand_arst", {bus2.state_dbg, bus2.restart, bus2.balls_left}, {3'd0, 1'b1, 3'(B2)});
                    step(); reset2 = 1'b0;
                    m_st = 0; m_t = 0; m_s1 = 0; m_s2 = 0; m_b = B2; m_r = 0;
                    p_eof = 0; p_col = 0; p_mis = 0;
                end
                bus2.endofframe = 1'($urandom_range(0, 1));
                bus2.isMoving   = ($urandom_range(0, 3) == 0);
                bus2.collided   = 2'($urandom_range(0, 3));
                bus2.missed     = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;

                ft  = bus2.endofframe && !p_eof;
                hit = |(bus2.collided & ~p_col);
                mr  = bus2.missed & ~p_mis;
                p_eof = bus2.endofframe; p_col = bus2.collided; p_mis = bus2.missed;
                m_clr = 0;
                if (m_st == 0) begin
                    if (bus2.isMoving) begin
                        m_clr = 1; m_s1 = 0; m_s2 = 0; m_r = 0; m_b = B2; m_t = SF2; m_st = 1;
                    end
                end else if (m_st == 1 || m_st == 3) begin
                    if (m_t == 0 && bus2.isMoving) begin
                        m_st = 2; m_r = 0;
                    end else if (ft && m_t > 0) m_t--;
                end else if (m_st == 2) begin
                    if (mr != 0) begin
                        int sc;
                        if (mr[0]) begin m_s2 = (m_s2 < 255) ? m_s2 + 1 : 255; sc = m_s2; end
                        else       begin m_s1 = (m_s1 < 255) ? m_s1 + 1 : 255; sc = m_s1; end
                        m_b = (m_b > 0) ? m_b - 1 : 0;
                        if (sc >= W2 || m_b == 0) begin m_st = 4; m_t = OF2; end
                        else                      begin m_st = 3; m_t = RF2; end
                    end else if (hit) m_r = (m_r < 255) ? m_r + 1 : 255;
                end else begin
                    if (m_t == 0) m_st = 0;
                    else if (ft) m_t--;
                end
                step();
                exp_v = {3'(m_st), 8'(m_s1), 8'(m_s2), 3'(m_b), 8'(m_r),
                         1'(m_clr), m_st != 2, m_st == 4};
                act_v = {bus2.state_dbg, bus2.score_one, bus2.score_two, bus2.balls_left,
                         bus2.rally, bus2.score_clr, bus2.restart, bus2.game_over};
                chk($sformatf("rand_c%0d", c), act_v, exp_v);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level Pong match controller that sequences the ball datapath (ball_movement) from the joystick/paddle and collision status.
- Runs the match lifecycle: idle, serve, play, ball refill, game over.
- Drives ball_movement's restart input and the score-clear pulse.
- Keeps per-player scores, remaining balls and a rally (hit) counter for the 7-segment and sound blocks.
- Replaces the inline FSM in pong_game.

Parameters:
BALLS, 3, balls per match (1..7).
WIN_SCORE, 9, score that ends the match (1..255).
SERVE_FRAMES, 60, frames ball is held centred before a serve can start.
REFILL_FRAMES, 127, frames held after a miss before re-serve.
OVER_FRAMES, 127, frames held in game-over before returning to idle.
TIMER_W, 7, frame-timer width; every *_FRAMES value must be < 2^TIMER_W.

Ports:
clk50M  in  1  system clock, 50 MHz.
reset  in  1  asynchronous, active-high reset.
endofframe  in  1  level from graphics; high while outside the display area.
isMoving  in  1  OR of both joystick isMoving flags.
collided  in  2  bit0 = left paddle hit, bit1 = right paddle hit (level).
missed  in  2  bit0 = left wall reached, bit1 = right wall reached (level).
restart  out  1  high = ball_movement holds ball at centre.
score_clr  out  1  one-cycle pulse clearing the score display.
score_one  out  8  left player score.
score_two  out  8  right player score.
balls_left  out  3  remaining balls.
rally  out  8  paddle hits since the last serve, saturating at 255.
game_over  out  1  high while in OVER.
state_dbg  out  3  current state encoding.

Behaviour:
- frame_tick: one-cycle pulse on each rising edge of endofframe; the edge-detect register resets to 0.
- collided and missed are edge-detected per bit, so an event counts once however many cycles the level persists.
- States (encoding): IDLE=0, SERVE=1, PLAY=2, REFILL=3, OVER=4. Unused codes go to IDLE on the next cycle.
- Reset values:
  - state=IDLE, restart=1, score_clr=0.
  - score_one=score_two=0, balls_left=BALLS, rally=0, game_over=0.
  - timer=0, edge-detect registers=0.
- IDLE:
  - restart=1.
  - When isMoving=1: pulse score_clr for one cycle; clear scores and rally; set balls_left=BALLS; load timer=SERVE_FRAMES; go to SERVE.
- SERVE:
  - restart=1.
  - timer decrements on frame_tick and holds at 0.
  - When timer==0 and isMoving=1: go to PLAY, clear rally.
- PLAY:
  - restart=0.
  - Rising edge of collided[0] or collided[1] (same cycle counts as one): rally+1, saturating.
  - Rising edge of missed:
    - missed[0] has priority when both rise in the same cycle.
    - missed[0] → score_two+1; missed[1] → score_one+1; scores saturate at 255.
    - balls_left-1.
    - If the new score ≥ WIN_SCORE or the new balls_left==0: load OVER_FRAMES, go to OVER. Otherwise load REFILL_FRAMES, go to REFILL.
  - A miss and a collision in the same cycle: the miss wins and the rally is not incremented.
- REFILL:
  - restart=1; timer counts down as in SERVE.
  - When timer==0 and isMoving=1: go to PLAY, clear rally.
- OVER:
  - restart=1, game_over=1; scores frozen.
  - When timer==0: go to IDLE. isMoving is ignored.
- collided/missed are ignored outside PLAY; counters change only in PLAY, except the clears made on the IDLE→SERVE transition.
- Latency:
  - state, restart and game_over change on the clock edge after the qualifying input.
  - restart falls one cycle after the serve condition.
- Timer: loads happen on transition; decrement occurs only on frame_tick; no wrap below 0.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous); restart=1 from reset onward.
- All outputs are registered except state_dbg, which is the state register itself.

Decomposition:
- Shared package pong_pkg holds:
  - state encodings;
  - PADDLE_WIDTH, PADDLE_LENGTH, PADDLE_ONE_X, PADDLE_TWO_X, BALL_SIZE;
  - default frame-count constants.
- One sub-module, frame_timer: loadable down-counter advanced by frame_tick, with a done flag.
- The edge detectors stay inline.

Test Plan:
- Reset then release; toggle endofframe at 1 pulse / 100 cycles; isMoving=1 → score_clr pulses once, SERVE, PLAY after 60 frame_ticks, restart=0.
- In PLAY, hold collided=01 for 5 cycles, then 10 and 11 on separate edges → rally=3, with no double count.
- In PLAY, missed=01 held 20 cycles → score_two=1, balls_left=2, REFILL; PLAY again only after 127 ticks with isMoving=1.
- Three misses with BALLS=3 → OVER with game_over=1, score_two=3; after 127 ticks → IDLE; isMoving held during OVER has no effect.
- WIN_SCORE=2, BALLS=7: two missed[1] events → score_one=2, OVER; missed=11 in the same cycle → only score_two increments and balls_left drops by 1.
- Assert reset mid-REFILL with timer=50 → state=IDLE, scores 0, balls_left=BALLS, restart=1 in the same cycle (asynchronous).
